// File: rtl/spram_arb_pkg.sv
// ---------------------------------------------------------------------------
// spram_arb_pkg
// Shared types and constants for the SPRAM arbiter.
//   state_t : arbiter phase (BOOT after reset, RUN once boot has completed)
//   owner_t : which requester issued the read whose data is returning next
//   SPRAM_WORDS : depth of the 16k x 32 single-port RAM
// ---------------------------------------------------------------------------
package spram_arb_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int SPRAM_WORDS = 16384;

endpackage

// File: rtl/spram_arb_perf.sv
// ---------------------------------------------------------------------------
// spram_arb_perf
// Bank of NUM saturating event counters, used by spram_arbiter when it is
// built with SPRAM_ARB_PERF_EN defined.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (zeros all counters)
//   clr      : synchronous clear; wins over an increment in the same cycle
//   inc[i]   : increment request for counter i
//   count[i] : counter value, sticks at all-ones
// ---------------------------------------------------------------------------
module spram_arb_perf #(
    parameter int CNT_W = 16,
    parameter int NUM   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [NUM-1:0]   inc,
    output logic [CNT_W-1:0] count [NUM]
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign count[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter
// Shares one 16k x 32 single-port SPRAM between requester A (CPU) and
// requester B (boot loader / DMA). After reset B owns the RAM exclusively
// until boot_done is seen; from then on A has fixed priority, except that
// once B has been stalled MAX_WAIT consecutive cycles B wins the next
// conflict. Read data returns one cycle after the grant on the shared rdata
// bus, qualified by the rvalid of the port that issued the read.
//
// Optional feature: define SPRAM_ARB_PERF_EN to add perf_clr and the
// saturating counters perf_a_grants / perf_b_grants / perf_conflicts.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   boot_done       ends the boot phase (sticky)
//   a_* / b_*       requester ports: valid, we (byte enables, 0 = read),
//                   addr, wdata, ready (combinational accept), rvalid
//   rdata           read data for whichever rvalid is high
//   ram_*           SPRAM pins; ram_rdata is the RAM's registered output
//   booting         high while in the boot phase
// ---------------------------------------------------------------------------
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    input  logic              a_valid,
    input  logic [3:0]        a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    input  logic              b_valid,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [31:0]       rdata,
    output logic              ram_sel,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              booting
`ifdef SPRAM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_a_grants,
    output logic [CNT_W-1:0]  perf_b_grants,
    output logic [CNT_W-1:0]  perf_conflicts
`endif
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_reg;
    owner_t     owner_reg;
    owner_t     owner_next;
    logic [7:0] starve_reg;
    logic       grant_a;
    logic       grant_b;
    logic       b_path;

    // Arbitration. In BOOT only B can be served; in RUN A wins unless B has
    // waited its full allowance.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_reg == BOOT) begin
            grant_b = b_valid;
        end else begin
            grant_a = a_valid && !(b_valid && (starve_reg == MAX_WAIT_C));
            grant_b = b_valid && !grant_a;
        end
    end

    // The RAM address/data mux follows B during boot and on a B grant;
    // otherwise it parks on A so an A access sees its address early.
    assign b_path    = (state_reg == BOOT) || grant_b;
    assign ram_sel   = grant_a || grant_b;
    assign ram_we    = ram_sel ? (b_path ? b_we : a_we) : 4'b0000;
    assign ram_addr  = b_path ? b_addr : a_addr;
    assign ram_wdata = b_path ? b_wdata : a_wdata;

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = (owner_reg == OWN_A);
    assign b_rvalid = (owner_reg == OWN_B);
    assign rdata    = ram_rdata;
    assign booting  = (state_reg == BOOT);

    // Remember who issued a read; the RAM's registered output belongs to
    // that port on the next cycle. Writes leave no owner.
    always_comb begin
        owner_next = OWN_NONE;
        if (grant_a && (a_we == 4'b0000)) begin
            owner_next = OWN_A;
        end else if (grant_b && (b_we == 4'b0000)) begin
            owner_next = OWN_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= BOOT;
            owner_reg  <= OWN_NONE;
            starve_reg <= 8'd0;
        end else begin
            owner_reg <= owner_next;
            if ((state_reg == BOOT) && boot_done) begin
                state_reg <= RUN;
            end
            // Counts consecutive stalled cycles of B; any grant or drop of
            // b_valid restarts the count.
            if (!b_valid || grant_b) begin
                starve_reg <= 8'd0;
            end else if (starve_reg != MAX_WAIT_C) begin
                starve_reg <= starve_reg + 8'd1;
            end
        end
    end

`ifdef SPRAM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_count [3];

    spram_arb_perf #(
        .CNT_W (CNT_W),
        .NUM   (3)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   ({(state_reg == RUN) && a_valid && b_valid, grant_b, grant_a}),
        .count (perf_count)
    );

    assign perf_a_grants  = perf_count[0];
    assign perf_b_grants  = perf_count[1];
    assign perf_conflicts = perf_count[2];
`endif

endmodule
